pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL provide parameter TIMEOUT, default 255, max MEMWAIT cycles before fault (1..255).
REQ-002 SHALL use reset reset_0, asynchronous, active-low; clock clock.
REQ-003 SHALL have ports: clock in 1, rising-edge clock; reset_0 in 1, async active-low reset.
REQ-004 SHALL have ports: rmem_ex in 1, EX holds load; rw_ex in 5, EX dest reg; rs_id, rt_id in 5 each, ID source regs; use_rs_id, use_rt_id in 1 each, ID reads rs/rt.
REQ-005 SHALL have ports: rmem_me, wmem_me in 1 each, ME load/store; dmem_ack in 1, data memory done; branch_taken_ex in 1, EX branch resolved taken; halt in 1, stop request.
REQ-006 SHALL have ports: en_pcif, en_ifid, en_idex, en_exme, en_mewb out 1 each, pipeline register enables; flush_ifid out 1, load NOP into IF/ID; bubble_idex out 1, load NOP into ID/EX.
REQ-007 SHALL have ports: dmem_req out 1, memory request; state out 2, FSM state; stall_cnt out 16, stall cycle count; mem_timeout out 1, sticky fault.

Function
REQ-008 SHALL implement FSM states RUN=0, LDUSE=1, MEMWAIT=2, HALTED=3, registered on rising clock.
REQ-009 SHALL drive all control outputs combinationally from current state and inputs (same-cycle response).
REQ-010 SHALL assert dmem_req = (rmem_me|wmem_me) in RUN, LDUSE, MEMWAIT; 0 in HALTED.
REQ-011 Memory stall: dmem_req=1 and dmem_ack=0 -> all en_* = 0, flush/bubble = 0, next state MEMWAIT.
REQ-012 MEMWAIT: hold dmem_req, all en_* = 0 until dmem_ack=1; ack cycle -> all en_* = 1, next RUN.
REQ-013 dmem_req=1 with dmem_ack=1 in same RUN cycle -> no stall, state stays RUN.
REQ-014 Load-use hazard = rmem_ex & rw_ex!=0 & ((use_rs_id & rs_id==rw_ex) | (use_rt_id & rt_id==rw_ex)).
REQ-015 Hazard in RUN without memory stall -> en_pcif=en_ifid=0, bubble_idex=1, en_idex=en_exme=en_mewb=1, next LDUSE.
REQ-016 LDUSE lasts exactly one cycle; hazard check suppressed; normal run/memory-stall rules apply; next RUN (or MEMWAIT per REQ-011).
REQ-017 Taken branch with no stall -> flush_ifid=1, bubble_idex=1, all en_* = 1.
REQ-018 Priority: HALTED > memory stall > load-use > branch; branch during stall is held in EX and acted on at release.
REQ-019 Branch and load-use same cycle -> branch wins: flush_ifid=1, bubble_idex=1, all en_*=1, next RUN.
REQ-020 No-event RUN -> all en_* = 1, flush_ifid=bubble_idex=0.
REQ-021 Internal 8-bit wait counter: cleared on MEMWAIT entry, +1 per MEMWAIT cycle without ack.
REQ-022 Wait counter reaching TIMEOUT without ack -> mem_timeout=1 (sticky), next HALTED.
REQ-023 halt=1 in any state -> next HALTED; halt takes effect after current cycle's outputs.
REQ-024 HALTED: all en_*, dmem_req, flush, bubble = 0; exit only via reset.
REQ-025 stall_cnt +1 each cycle en_pcif=0 and state!=HALTED; saturates at 16'hFFFF.

Reset
REQ-026 reset_0=0 -> state=RUN, stall_cnt=0, wait counter=0, mem_timeout=0 asynchronously.
REQ-027 While reset_0=0 all en_*, dmem_req, flush_ifid, bubble_idex SHALL be 0.
REQ-028 Reset mid-MEMWAIT or HALTED -> RUN immediately; pending request dropped.

Verification
REQ-029 Load-use: rmem_ex=1, rw_ex=5, rs_id=5, use_rs_id=1 -> one cycle en_pcif=en_ifid=0, bubble_idex=1, state LDUSE then RUN, stall_cnt=1.
REQ-030 rw_ex=0 with rs_id=0, use_rs_id=1, rmem_ex=1 -> no stall, all en_*=1.
REQ-031 rmem_me=1, dmem_ack low 3 cycles then high -> en_*=0 for 3 cycles, 1 on ack cycle, stall_cnt=3, state 2 then 0.
REQ-032 Branch during 2-cycle memory stall -> no flush while stalled; flush_ifid=bubble_idex=1 on ack cycle.
REQ-033 TIMEOUT=4, wmem_me=1, ack never -> mem_timeout=1, state=3, outputs 0; reset_0 pulse -> state 0, mem_timeout 0.
REQ-034 halt=1 for one cycle in RUN -> state 3 next cycle, stall_cnt frozen thereafter.

Source files
------------

// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl
//   Hazard / stall controller for a 5-stage in-order pipeline.
//   It produces the pipeline-register enables and the flush/bubble controls
//   that resolve load-use hazards, taken branches, data-memory stalls, a
//   memory-timeout fault and an external halt request.
//
// Parameters
//   TIMEOUT          maximum MEMWAIT cycles without ack before a fault (1..255)
//
// Ports
//   clock            rising-edge clock
//   reset_0          asynchronous, active-low reset
//   rmem_ex          EX stage holds a load
//   rw_ex[4:0]       EX stage destination register
//   rs_id, rt_id     ID stage source registers
//   use_rs_id/rt_id  ID stage actually reads rs / rt
//   rmem_me/wmem_me  ME stage holds a load / store
//   dmem_ack         data memory completes the access this cycle
//   branch_taken_ex  EX stage resolved a taken branch
//   halt             stop request (takes effect after the current cycle)
//   en_pcif..en_mewb pipeline register enables
//   flush_ifid       load a NOP into IF/ID
//   bubble_idex      load a NOP into ID/EX
//   dmem_req         data memory request
//   state[1:0]       FSM state (RUN=0, LDUSE=1, MEMWAIT=2, HALTED=3)
//   stall_cnt[15:0]  saturating count of cycles with the front end stalled
//   mem_timeout      sticky memory-timeout fault
// -----------------------------------------------------------------------------
module pipe_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        reset_0,
    input  logic        rmem_ex,
    input  logic [4:0]  rw_ex,
    input  logic [4:0]  rs_id,
    input  logic [4:0]  rt_id,
    input  logic        use_rs_id,
    input  logic        use_rt_id,
    input  logic        rmem_me,
    input  logic        wmem_me,
    input  logic        dmem_ack,
    input  logic        branch_taken_ex,
    input  logic        halt,
    output logic        en_pcif,
    output logic        en_ifid,
    output logic        en_idex,
    output logic        en_exme,
    output logic        en_mewb,
    output logic        flush_ifid,
    output logic        bubble_idex,
    output logic        dmem_req,
    output logic [1:0]  state,
    output logic [15:0] stall_cnt,
    output logic        mem_timeout
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LDUSE   = 2'd1,
        MEMWAIT = 2'd2,
        HALTED  = 2'd3
    } state_t;

    localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT);

    state_t     cur_state;
    state_t     nxt_state;
    logic [7:0] wait_cnt;
    logic [7:0] wait_cnt_nxt;
    logic       timeout_hit;

    logic       mem_access;
    logic       mem_stall;
    logic       load_use;

    // Internal (unmasked) control decisions; reset masking is applied last.
    logic       en_front;   // en_pcif / en_ifid
    logic       en_back;    // en_idex / en_exme / en_mewb
    logic       flush_c;
    logic       bubble_c;
    logic       req_c;

    assign mem_access = rmem_me | wmem_me;
    assign mem_stall  = mem_access & ~dmem_ack;

    assign load_use = rmem_ex & (rw_ex != 5'd0) &
                      ((use_rs_id & (rs_id == rw_ex)) |
                       (use_rt_id & (rt_id == rw_ex)));

    // -------------------------------------------------------------------------
    // Next-state and control decode
    // -------------------------------------------------------------------------
    always_comb begin
        nxt_state    = cur_state;
        wait_cnt_nxt = wait_cnt;
        timeout_hit  = 1'b0;
        en_front     = 1'b0;
        en_back      = 1'b0;
        flush_c      = 1'b0;
        bubble_c     = 1'b0;
        req_c        = 1'b0;

        unique case (cur_state)
            RUN, LDUSE: begin
                req_c = mem_access;
                if (mem_stall) begin
                    // Whole pipe frozen; a branch in EX stays put and is
                    // handled when the memory access releases.
                    nxt_state    = MEMWAIT;
                    wait_cnt_nxt = '0;
                end else if (branch_taken_ex) begin
                    // Branch beats load-use: the dependent instruction in ID
                    // is on the wrong path and gets flushed anyway.
                    en_front  = 1'b1;
                    en_back   = 1'b1;
                    flush_c   = 1'b1;
                    bubble_c  = 1'b1;
                    nxt_state = RUN;
                end else if ((cur_state == RUN) && load_use) begin
                    en_back   = 1'b1;
                    bubble_c  = 1'b1;
                    nxt_state = LDUSE;
                end else begin
                    en_front  = 1'b1;
                    en_back   = 1'b1;
                    nxt_state = RUN;
                end
            end

            MEMWAIT: begin
                req_c = mem_access;
                if (mem_stall) begin
                    wait_cnt_nxt = wait_cnt + 8'd1;
                    if (wait_cnt_nxt == TIMEOUT_LIM) begin
                        timeout_hit = 1'b1;
                        nxt_state   = HALTED;
                    end
                end else begin
                    en_front  = 1'b1;
                    en_back   = 1'b1;
                    flush_c   = branch_taken_ex;
                    bubble_c  = branch_taken_ex;
                    nxt_state = RUN;
                end
            end

            HALTED: begin
                nxt_state = HALTED;
            end

            default: begin
                nxt_state = RUN;
            end
        endcase

        // Halt only redirects the next state; this cycle's controls stand.
        if (halt) begin
            nxt_state = HALTED;
        end
    end

    // Controls are forced inactive while reset is asserted.
    always_comb begin
        en_pcif     = en_front & reset_0;
        en_ifid     = en_front & reset_0;
        en_idex     = en_back  & reset_0;
        en_exme     = en_back  & reset_0;
        en_mewb     = en_back  & reset_0;
        flush_ifid  = flush_c  & reset_0;
        bubble_idex = bubble_c & reset_0;
        dmem_req    = req_c    & reset_0;
    end

    assign state = cur_state;

    // -------------------------------------------------------------------------
    // State, wait counter, fault flag and stall statistics
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_0) begin
        if (!reset_0) begin
            cur_state   <= RUN;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
            stall_cnt   <= '0;
        end else begin
            cur_state <= nxt_state;
            wait_cnt  <= wait_cnt_nxt;
            if (timeout_hit) begin
                mem_timeout <= 1'b1;
            end
            if (!en_front && (cur_state != HALTED) && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

    logic        clock;
    logic        reset_0;
    logic        rmem_ex;
    logic [4:0]  rw_ex;
    logic [4:0]  rs_id;
    logic [4:0]  rt_id;
    logic        use_rs_id;
    logic        use_rt_id;
    logic        rmem_me;
    logic        wmem_me;
    logic        dmem_ack;
    logic        branch_taken_ex;
    logic        halt;
    logic        en_pcif, en_ifid, en_idex, en_exme, en_mewb;
    logic        flush_ifid, bubble_idex, dmem_req;
    logic [1:0]  state;
    logic [15:0] stall_cnt;
    logic        mem_timeout;

    logic [4:0]  en_v;
    assign en_v = {en_pcif, en_ifid, en_idex, en_exme, en_mewb};

    int errors = 0;
    int checks = 0;

    pipe_ctrl #(.TIMEOUT(4)) dut (
        .clock           (clock),
        .reset_0         (reset_0),
        .rmem_ex         (rmem_ex),
        .rw_ex           (rw_ex),
        .rs_id           (rs_id),
        .rt_id           (rt_id),
        .use_rs_id       (use_rs_id),
        .use_rt_id       (use_rt_id),
        .rmem_me         (rmem_me),
        .wmem_me         (wmem_me),
        .dmem_ack        (dmem_ack),
        .branch_taken_ex (branch_taken_ex),
        .halt            (halt),
        .en_pcif         (en_pcif),
        .en_ifid         (en_ifid),
        .en_idex         (en_idex),
        .en_exme         (en_exme),
        .en_mewb         (en_mewb),
        .flush_ifid      (flush_ifid),
        .bubble_idex     (bubble_idex),
        .dmem_req        (dmem_req),
        .state           (state),
        .stall_cnt       (stall_cnt),
        .mem_timeout     (mem_timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        rmem_ex = 0; rw_ex = 0; rs_id = 0; rt_id = 0;
        use_rs_id = 0; use_rt_id = 0; rmem_me = 0; wmem_me = 0;
        dmem_ack = 0; branch_taken_ex = 0; halt = 0;
    endtask

    // Advance to just after the next rising edge, then let inputs settle.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    // Compact check of the combinational control group.
    task automatic check_ctl(input string tag, input logic [4:0] en_e,
                             input logic fl_e, input logic bu_e, input logic rq_e);
        check({tag, ".en"},     en_v,        en_e);
        check({tag, ".flush"},  flush_ifid,  fl_e);
        check({tag, ".bubble"}, bubble_idex, bu_e);
        check({tag, ".req"},    dmem_req,    rq_e);
    endtask

    initial begin
        idle();
        reset_0 = 0;
        rmem_me = 1;                         // outputs must stay low in reset anyway
        #12;
        check_ctl("rst", 5'b00000, 0, 0, 0);
        check("rst.state", state, 0);
        check("rst.stall_cnt", stall_cnt, 0);
        check("rst.timeout", mem_timeout, 0);
        step();
        reset_0 = 1;
        idle();
        settle();

        // No-event RUN
        check_ctl("idle", 5'b11111, 0, 0, 0);

        // r0 is never a hazard
        rmem_ex = 1; rw_ex = 0; rs_id = 0; use_rs_id = 1;
        settle();
        check_ctl("r0", 5'b11111, 0, 0, 0);

        // rs-side load-use; inputs held through LDUSE to show the check is suppressed
        step();
        rmem_ex = 1; rw_ex = 5; rs_id = 5; use_rs_id = 1;
        settle();
        check_ctl("lu_rs", 5'b00111, 0, 1, 0);
        step(); settle();
        check("lu_rs.state1", state, 1);
        check_ctl("lu_rs.ld", 5'b11111, 0, 0, 0);
        step(); idle(); settle();
        check("lu_rs.state2", state, 0);
        check("lu_rs.stall_cnt", stall_cnt, 1);

        // rt-side load-use
        rmem_ex = 1; rw_ex = 7; rs_id = 7; use_rs_id = 0; rt_id = 7; use_rt_id = 1;
        settle();
        check_ctl("lu_rt", 5'b00111, 0, 1, 0);
        step(); idle(); settle();
        check("lu_rt.state", state, 1);
        step(); settle();
        check("lu_rt.stall_cnt", stall_cnt, 2);

        // Matching register but not read -> no hazard
        rmem_ex = 1; rw_ex = 9; rs_id = 9; use_rs_id = 0; rt_id = 9; use_rt_id = 0;
        settle();
        check_ctl("nouse", 5'b11111, 0, 0, 0);
        step(); idle(); settle();

        // Load with ack low for three cycles
        rmem_me = 1;
        settle();
        check_ctl("ms.c0", 5'b00000, 0, 0, 1);
        step(); settle();
        check("ms.c1.state", state, 2);
        check_ctl("ms.c1", 5'b00000, 0, 0, 1);
        step(); settle();
        check_ctl("ms.c2", 5'b00000, 0, 0, 1);
        step(); dmem_ack = 1; settle();
        check("ms.ack.state", state, 2);
        check_ctl("ms.ack", 5'b11111, 0, 0, 1);
        step(); idle(); settle();
        check("ms.state", state, 0);
        check("ms.stall_cnt", stall_cnt, 5);

        // Same-cycle ack: no stall
        rmem_me = 1; dmem_ack = 1;
        settle();
        check_ctl("ack0", 5'b11111, 0, 0, 1);
        step(); idle(); settle();
        check("ack0.state", state, 0);

        // Taken branch
        branch_taken_ex = 1;
        settle();
        check_ctl("br", 5'b11111, 1, 1, 0);
        // Branch with load-use: branch wins
        rmem_ex = 1; rw_ex = 3; rt_id = 3; use_rt_id = 1;
        settle();
        check_ctl("br_lu", 5'b11111, 1, 1, 0);
        step(); idle(); settle();
        check("br_lu.state", state, 0);
        check("br_lu.stall_cnt", stall_cnt, 5);

        // Branch held during a 2-cycle store stall
        wmem_me = 1; branch_taken_ex = 1;
        settle();
        check_ctl("bs.c0", 5'b00000, 0, 0, 1);
        step(); settle();
        check_ctl("bs.c1", 5'b00000, 0, 0, 1);
        step(); dmem_ack = 1; settle();
        check_ctl("bs.ack", 5'b11111, 1, 1, 1);
        step(); idle(); settle();
        check("bs.state", state, 0);
        check("bs.stall_cnt", stall_cnt, 7);

        // Timeout with TIMEOUT=4: entry cycle + 4 MEMWAIT cycles, then HALTED
        wmem_me = 1;
        settle();
        for (int i = 1; i <= 4; i++) begin
            step(); settle();
            check($sformatf("to.wait%0d.state", i), state, 2);
            check($sformatf("to.wait%0d.flag", i), mem_timeout, 0);
        end
        step(); settle();
        check("to.state", state, 3);
        check("to.flag", mem_timeout, 1);
        check_ctl("to.halted", 5'b00000, 0, 0, 0);
        check("to.stall_cnt", stall_cnt, 12);
        step(); step(); settle();
        check("to.stall_frozen", stall_cnt, 12);
        check("to.state_hold", state, 3);

        // Reset pulse clears the fault asynchronously
        reset_0 = 0;
        #1;
        check("rp.state", state, 0);
        check("rp.flag", mem_timeout, 0);
        check("rp.stall_cnt", stall_cnt, 0);
        check_ctl("rp", 5'b00000, 0, 0, 0);
        #1;
        reset_0 = 1;
        idle();
        step(); settle();
        check_ctl("rp.run", 5'b11111, 0, 0, 0);

        // One stall cycle, then halt
        rmem_ex = 1; rw_ex = 12; rs_id = 12; use_rs_id = 1;
        step(); idle(); step(); settle();
        check("hl.pre_cnt", stall_cnt, 1);
        halt = 1;
        settle();
        check_ctl("hl.same", 5'b11111, 0, 0, 0);
        step(); halt = 0; rmem_me = 1; settle();
        check("hl.state", state, 3);
        check_ctl("hl.halted", 5'b00000, 0, 0, 0);
        step(); step(); step(); settle();
        check("hl.state_hold", state, 3);
        check("hl.stall_cnt", stall_cnt, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
